ecpri_resp_sched: RTL and testbench

- Scheduler between the eCPRI receive parser and the eCPRI transmit builder.
- Queues write-response and read-response requests raised by the parser and issues them one at a time to the transmit builder, using a start/done handshake with a timeout.
- Also arbitrates the single shared payload-memory port between the receive copy path and the transmit read path.

---
 rtl/ecpri_resp_sched_pkg.sv | 22 ++
 rtl/ecpri_resp_sched_if.sv | 42 ++++
 rtl/ecpri_resp_sched_fifo.sv | 54 +++++
 rtl/ecpri_resp_sched.sv | 184 ++++++++++++++++++
 tb/tb_ecpri_resp_sched.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ecpri_resp_sched_pkg.sv
// Shared types and constants for the eCPRI response scheduler.
package ecpri_pkg;

   localparam int DEF_LEN_W  = 16;
   localparam int DEF_ADDR_W = 8;

   localparam logic KIND_WR = 1'b0;
   localparam logic KIND_RD = 1'b1;

   typedef struct packed {
      logic                  kind;
      logic [DEF_LEN_W-1:0]  len;
      logic [DEF_ADDR_W-1:0] addr;
   } ecpri_req_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } sched_state_t;

endpackage

// File: rtl/ecpri_resp_sched_if.sv
// Bundle of request, transmit-handshake and memory-arbitration signals
// between the scheduler and its surrounding receive/transmit blocks.
interface ecpri_resp_sched_if #(
   parameter int LEN_W  = 16,
   parameter int ADDR_W = 8,
   parameter int QDEPTH = 4
);
   localparam int CNT_W = $clog2(QDEPTH) + 1;

   logic              wr_req;
   logic              rd_req;
   logic [LEN_W-1:0]  req_len;
   logic [ADDR_W-1:0] req_addr;
   logic              tx_start;
   logic              tx_kind;
   logic [LEN_W-1:0]  tx_len;
   logic [ADDR_W-1:0] tx_addr;
   logic              tx_done;
   logic              rx_mem_req;
   logic              tx_mem_req;
   logic              mem_gnt_rx;
   logic              mem_gnt_tx;
   logic [CNT_W-1:0]  q_count;
   logic              overflow;
   logic              tx_timeout;
   logic [7:0]        drop_cnt;

   // Scheduler side.
   modport master (
      input  wr_req, rd_req, req_len, req_addr, tx_done, rx_mem_req, tx_mem_req,
      output tx_start, tx_kind, tx_len, tx_addr, mem_gnt_rx, mem_gnt_tx,
             q_count, overflow, tx_timeout, drop_cnt
   );

   // Parser / builder / memory-client side.
   modport slave (
      output wr_req, rd_req, req_len, req_addr, tx_done, rx_mem_req, tx_mem_req,
      input  tx_start, tx_kind, tx_len, tx_addr, mem_gnt_rx, mem_gnt_tx,
             q_count, overflow, tx_timeout, drop_cnt
   );

endinterface

// File: rtl/ecpri_resp_sched_fifo.sv
// Request FIFO accepting up to two entries and releasing one per cycle.
// A second push lands directly behind the first; push1 alone uses the
// current write slot.
module ecpri_req_fifo #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 4
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push0,
   input  logic [WIDTH-1:0]           data0,
   input  logic                       push1,
   input  logic [WIDTH-1:0]           data1,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH):0]     free,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] occ;
   logic [1:0]       n_push;

   assign n_push = {1'b0, push0} + {1'b0, push1};
   assign head   = mem[rd_ptr];
   assign free   = CNT_W'(DEPTH) - occ;
   assign count  = occ;

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(n_push);
         rd_ptr <= rd_ptr + PTR_W'(pop);
         occ    <= occ + CNT_W'(n_push) - CNT_W'(pop);
      end
   end

   // Entry storage needs no reset: occupancy decides what is valid.
   always_ff @(posedge clk) begin
      if (push0)
         mem[wr_ptr] <= data0;
      if (push1)
         mem[wr_ptr + PTR_W'(push0)] <= data1;
   end

endmodule

// File: rtl/ecpri_resp_sched.sv
// eCPRI response scheduler: queues write/read response requests, issues
// them one at a time to the transmit builder with a done/timeout
// handshake, and arbitrates the shared payload-memory port.
module ecpri_resp_sched
   import ecpri_pkg::*;
#(
   parameter int LEN_W   = DEF_LEN_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int QDEPTH  = 4,
   parameter int TIMEOUT = 1024
)(
   input logic                 inp_clk,
   input logic                 reset,
   ecpri_resp_sched_if.master  bus
);
   localparam int CNT_W   = $clog2(QDEPTH) + 1;
   localparam int ENTRY_W = 1 + LEN_W + ADDR_W;
   localparam int TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   sched_state_t       state;
   sched_state_t       next_state;
   logic               pop;
   logic               tx_start;
   logic               tx_timeout;
   logic [TO_W-1:0]    to_cnt;

   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] rd_entry;
   logic [ENTRY_W-1:0] data0;
   logic [ENTRY_W-1:0] data1;
   logic [ENTRY_W-1:0] head;
   logic               push0;
   logic               push1;
   logic [CNT_W-1:0]   free;
   logic [CNT_W-1:0]   count;
   logic [CNT_W:0]     space;
   logic [1:0]         n_drop;
   logic [8:0]         drop_sum;

   logic               tx_kind_q;
   logic [LEN_W-1:0]   tx_len_q;
   logic [ADDR_W-1:0]  tx_addr_q;
   logic               overflow_q;
   logic [7:0]         drop_cnt_q;
   logic               gnt_rx;
   logic               gnt_tx;

   assign wr_entry = {KIND_WR, bus.req_len, bus.req_addr};
   assign rd_entry = {KIND_RD, bus.req_len, bus.req_addr};

   // Space seen by new requests includes the slot freed by a same-cycle pop.
   assign space    = {1'b0, free} + {{CNT_W{1'b0}}, pop};
   assign drop_sum = {1'b0, drop_cnt_q} + {7'd0, n_drop};

   ecpri_req_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk   (inp_clk),
      .rst   (reset),
      .push0 (push0),
      .data0 (data0),
      .push1 (push1),
      .data1 (data1),
      .pop   (pop),
      .head  (head),
      .free  (free),
      .count (count)
   );

   // Admit requests write-first while space remains; whatever does not fit is dropped.
   always_comb begin
      push0  = 1'b0;
      push1  = 1'b0;
      data0  = wr_entry;
      data1  = rd_entry;
      n_drop = 2'd0;
      if (bus.wr_req && bus.rd_req) begin
         if (space > {{CNT_W{1'b0}}, 1'b1}) begin
            push0 = 1'b1;
            push1 = 1'b1;
         end else if (space != '0) begin
            push0  = 1'b1;
            n_drop = 2'd1;
         end else begin
            n_drop = 2'd2;
         end
      end else if (bus.wr_req || bus.rd_req) begin
         data0 = bus.wr_req ? wr_entry : rd_entry;
         if (space != '0)
            push0 = 1'b1;
         else
            n_drop = 2'd1;
      end
   end

   // Overflow pulse and saturating drop counter.
   always_ff @(posedge inp_clk or posedge reset) begin
      if (reset) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         overflow_q <= (n_drop != 2'd0);
         drop_cnt_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end

   // Issue FSM: next state, pop strobe and the start/timeout pulses.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      tx_start   = 1'b0;
      tx_timeout = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop        = 1'b1;
               next_state = ISSUE;
            end
         end
         ISSUE: begin
            tx_start   = 1'b1;
            next_state = WAIT;
         end
         WAIT: begin
            if (bus.tx_done) begin
               next_state = IDLE;
            end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
               tx_timeout = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State register, timeout counter and the held response descriptor.
   always_ff @(posedge inp_clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         to_cnt    <= '0;
         tx_kind_q <= 1'b0;
         tx_len_q  <= '0;
         tx_addr_q <= '0;
      end else begin
         state <= next_state;
         if (state == ISSUE)
            to_cnt <= '0;
         else if (state == WAIT && !bus.tx_done)
            to_cnt <= to_cnt + TO_W'(1);
         if (pop)
            {tx_kind_q, tx_len_q, tx_addr_q} <= head;
      end
   end

   // Memory port arbiter: holder keeps the port until its request drops,
   // an idle port goes to receive first.
   always_ff @(posedge inp_clk or posedge reset) begin
      if (reset) begin
         gnt_rx <= 1'b0;
         gnt_tx <= 1'b0;
      end else if (gnt_rx) begin
         gnt_rx <= bus.rx_mem_req;
      end else if (gnt_tx) begin
         gnt_tx <= bus.tx_mem_req;
      end else if (bus.rx_mem_req) begin
         gnt_rx <= 1'b1;
      end else if (bus.tx_mem_req) begin
         gnt_tx <= 1'b1;
      end
   end

   assign bus.tx_start   = tx_start;
   assign bus.tx_kind    = tx_kind_q;
   assign bus.tx_len     = tx_len_q;
   assign bus.tx_addr    = tx_addr_q;
   assign bus.mem_gnt_rx = gnt_rx;
   assign bus.mem_gnt_tx = gnt_tx;
   assign bus.q_count    = count;
   assign bus.overflow   = overflow_q;
   assign bus.tx_timeout = tx_timeout;
   assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_ecpri_resp_sched.sv
// Self-checking bench for the eCPRI response scheduler: directed
// scenarios plus a randomized run against a queue-based reference model.
module tb_ecpri_resp_sched;
   import ecpri_pkg::*;

   localparam int LEN_W   = 16;
   localparam int ADDR_W  = 8;
   localparam int QDEPTH  = 4;
   localparam int TIMEOUT = 1024;
   localparam int OUT_W   = 1 + 1 + LEN_W + ADDR_W + 1 + 1 + ($clog2(QDEPTH) + 1) + 1 + 1 + 8;

   logic inp_clk = 1'b0;
   logic reset   = 1'b1;
   int   tests   = 0;
   int   fails   = 0;

   ecpri_resp_sched_if #(.LEN_W(LEN_W), .ADDR_W(ADDR_W), .QDEPTH(QDEPTH)) bus ();

   ecpri_resp_sched #(
      .LEN_W   (LEN_W),
      .ADDR_W  (ADDR_W),
      .QDEPTH  (QDEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .inp_clk (inp_clk),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 inp_clk = ~inp_clk;

   function automatic logic [OUT_W-1:0] all_outputs();
      return {bus.tx_start, bus.tx_kind, bus.tx_len, bus.tx_addr, bus.mem_gnt_rx,
              bus.mem_gnt_tx, bus.q_count, bus.overflow, bus.tx_timeout, bus.drop_cnt};
   endfunction

   task automatic step();
      @(negedge inp_clk);
      bus.wr_req  = 1'b0;
      bus.rd_req  = 1'b0;
      bus.tx_done = 1'b0;
   endtask

   task automatic do_reset();
      bus.wr_req     = 1'b0;
      bus.rd_req     = 1'b0;
      bus.req_len    = '0;
      bus.req_addr   = '0;
      bus.tx_done    = 1'b0;
      bus.rx_mem_req = 1'b0;
      bus.tx_mem_req = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge inp_clk);
      reset = 1'b0;
   endtask

   task automatic wait_start(input int limit, output int cycles);
      cycles = -1;
      for (int i = 1; i <= limit; i++) begin
         step();
         if (bus.tx_start === 1'b1) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic ack();
      step();
      bus.tx_done = 1'b1;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      reset = 1'b1;
      #1;
      tests++;
      if (all_outputs() !== '0) begin
         fails++;
         $display("[TB] FAIL reset_outputs: got %h, expected 0", all_outputs());
      end
      @(negedge inp_clk);
      reset = 1'b0;
      step();
      tests++;
      if (all_outputs() !== '0) begin
         fails++;
         $display("[TB] FAIL reset_release_outputs: got %h, expected 0", all_outputs());
      end
   endtask

   task automatic test_single();
      int lat;
      bus.wr_req   = 1'b1;
      bus.req_len  = 16'd8;
      bus.req_addr = 8'h13;
      wait_start(10, lat);
      tests++;
      if (lat !== 2) begin
         fails++;
         $display("[TB] FAIL single_latency: got %0d, expected 2", lat);
      end
      tests++;
      if ({bus.tx_kind, bus.tx_len, bus.tx_addr} !== {KIND_WR, 16'd8, 8'h13}) begin
         fails++;
         $display("[TB] FAIL single_fields: got kind=%0d len=%0d addr=%h, expected 0/8/13",
                  bus.tx_kind, bus.tx_len, bus.tx_addr);
      end
      repeat (4) step();
      bus.tx_done = 1'b1;
      step();
      step();
      tests++;
      if (bus.q_count !== 3'd0 || bus.tx_start !== 1'b0) begin
         fails++;
         $display("[TB] FAIL single_drain: got q_count=%0d tx_start=%0d, expected 0/0",
                  bus.q_count, bus.tx_start);
      end
      tests++;
      if (bus.tx_len !== 16'd8) begin
         fails++;
         $display("[TB] FAIL single_hold: got len=%0d, expected 8", bus.tx_len);
      end
   endtask

   task automatic test_pair();
      int lat;
      bus.wr_req   = 1'b1;
      bus.rd_req   = 1'b1;
      bus.req_len  = 16'd4;
      bus.req_addr = 8'h20;
      wait_start(10, lat);
      tests++;
      if (lat !== 2 || {bus.tx_kind, bus.tx_len, bus.tx_addr} !== {KIND_WR, 16'd4, 8'h20}) begin
         fails++;
         $display("[TB] FAIL pair_first: got lat=%0d kind=%0d len=%0d addr=%h, expected 2/0/4/20",
                  lat, bus.tx_kind, bus.tx_len, bus.tx_addr);
      end
      tests++;
      if (bus.q_count !== 3'd1) begin
         fails++;
         $display("[TB] FAIL pair_qcount: got %0d, expected 1", bus.q_count);
      end
      ack();
      wait_start(10, lat);
      tests++;
      if (lat !== 1 || {bus.tx_kind, bus.tx_len, bus.tx_addr} !== {KIND_RD, 16'd4, 8'h20}) begin
         fails++;
         $display("[TB] FAIL pair_second: got lat=%0d kind=%0d len=%0d addr=%h, expected 1/1/4/20",
                  lat, bus.tx_kind, bus.tx_len, bus.tx_addr);
      end
      ack();
   endtask

   task automatic test_overflow();
      int lat;
      int first;
      int ovf;
      do_reset();
      first = -1;
      ovf   = 0;
      for (int i = 0; i < 6; i++) begin
         bus.wr_req   = 1'b1;
         bus.req_len  = 16'(100 + i);
         bus.req_addr = 8'(8'h40 + i);
         step();
         if (bus.tx_start === 1'b1 && first < 0) first = i;
         if (bus.overflow === 1'b1) ovf++;
      end
      step();
      if (bus.overflow === 1'b1) ovf++;
      tests++;
      if (ovf !== 1 || bus.drop_cnt !== 8'd1) begin
         fails++;
         $display("[TB] FAIL ovf_pulse: got pulses=%0d drop_cnt=%0d, expected 1/1", ovf, bus.drop_cnt);
      end
      tests++;
      if (bus.q_count !== 3'd4 || first !== 1 || bus.tx_len !== 16'd100) begin
         fails++;
         $display("[TB] FAIL ovf_queue: got q=%0d first=%0d len=%0d, expected 4/1/100",
                  bus.q_count, first, bus.tx_len);
      end
      ack();
      for (int k = 1; k <= 4; k++) begin
         wait_start(5, lat);
         tests++;
         if (lat !== 1 || bus.tx_len !== 16'(100 + k)) begin
            fails++;
            $display("[TB] FAIL ovf_drain_%0d: got lat=%0d len=%0d, expected 1/%0d",
                     k, lat, bus.tx_len, 100 + k);
         end
         ack();
      end
      wait_start(8, lat);
      tests++;
      if (lat !== -1 || bus.q_count !== 3'd0) begin
         fails++;
         $display("[TB] FAIL ovf_dropped_issued: got lat=%0d q=%0d, expected -1/0", lat, bus.q_count);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 140; i++) begin
         bus.wr_req   = 1'b1;
         bus.rd_req   = 1'b1;
         bus.req_len  = 16'(i);
         bus.req_addr = 8'(i);
         step();
         if (i == 2) begin
            tests++;
            if (bus.drop_cnt !== 8'd1 || bus.q_count !== 3'd4) begin
               fails++;
               $display("[TB] FAIL sat_partial: got drop=%0d q=%0d, expected 1/4",
                        bus.drop_cnt, bus.q_count);
            end
         end
      end
      tests++;
      if (bus.drop_cnt !== 8'd255 || bus.overflow !== 1'b1) begin
         fails++;
         $display("[TB] FAIL sat_cap: got drop=%0d ovf=%0d, expected 255/1", bus.drop_cnt, bus.overflow);
      end
      step();
      tests++;
      if (bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd255) begin
         fails++;
         $display("[TB] FAIL sat_quiet: got ovf=%0d drop=%0d, expected 0/255", bus.overflow, bus.drop_cnt);
      end
   endtask

   task automatic test_timeout();
      int lat;
      int t;
      do_reset();
      bus.wr_req   = 1'b1;
      bus.rd_req   = 1'b1;
      bus.req_len  = 16'd0;
      bus.req_addr = 8'h77;
      wait_start(10, lat);
      t = -1;
      for (int k = 1; k <= TIMEOUT + 8; k++) begin
         step();
         if (bus.tx_timeout === 1'b1) begin
            t = k;
            break;
         end
      end
      tests++;
      if (lat !== 2 || t !== TIMEOUT) begin
         fails++;
         $display("[TB] FAIL timeout_delay: got lat=%0d delay=%0d, expected 2/%0d", lat, t, TIMEOUT);
      end
      step();
      tests++;
      if (bus.tx_timeout !== 1'b0) begin
         fails++;
         $display("[TB] FAIL timeout_pulse_width: got %0d, expected 0", bus.tx_timeout);
      end
      wait_start(5, lat);
      tests++;
      if (lat !== 1 || {bus.tx_kind, bus.tx_len, bus.tx_addr} !== {KIND_RD, 16'd0, 8'h77}) begin
         fails++;
         $display("[TB] FAIL timeout_next: got lat=%0d kind=%0d len=%0d addr=%h, expected 1/1/0/77",
                  lat, bus.tx_kind, bus.tx_len, bus.tx_addr);
      end
      ack();
   endtask

   task automatic test_arbiter();
      do_reset();
      bus.rx_mem_req = 1'b1;
      bus.tx_mem_req = 1'b1;
      step();
      tests++;
      if ({bus.mem_gnt_rx, bus.mem_gnt_tx} !== 2'b10) begin
         fails++;
         $display("[TB] FAIL arb_tie: got rx/tx=%b, expected 10", {bus.mem_gnt_rx, bus.mem_gnt_tx});
      end
      repeat (2) step();
      bus.rx_mem_req = 1'b0;
      step();
      tests++;
      if ({bus.mem_gnt_rx, bus.mem_gnt_tx} !== 2'b00) begin
         fails++;
         $display("[TB] FAIL arb_gap: got rx/tx=%b, expected 00", {bus.mem_gnt_rx, bus.mem_gnt_tx});
      end
      step();
      tests++;
      if ({bus.mem_gnt_rx, bus.mem_gnt_tx} !== 2'b01) begin
         fails++;
         $display("[TB] FAIL arb_switch: got rx/tx=%b, expected 01", {bus.mem_gnt_rx, bus.mem_gnt_tx});
      end
      bus.rx_mem_req = 1'b1;
      repeat (2) step();
      tests++;
      if ({bus.mem_gnt_rx, bus.mem_gnt_tx} !== 2'b01) begin
         fails++;
         $display("[TB] FAIL arb_no_preempt: got rx/tx=%b, expected 01", {bus.mem_gnt_rx, bus.mem_gnt_tx});
      end
      bus.tx_mem_req = 1'b0;
      step();
      step();
      tests++;
      if ({bus.mem_gnt_rx, bus.mem_gnt_tx} !== 2'b10) begin
         fails++;
         $display("[TB] FAIL arb_back_to_rx: got rx/tx=%b, expected 10", {bus.mem_gnt_rx, bus.mem_gnt_tx});
      end
      bus.rx_mem_req = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      int lat;
      int seen;
      do_reset();
      bus.rx_mem_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.rd_req   = 1'b1;
         bus.req_len  = 16'(16'h300 + i);
         bus.req_addr = 8'(8'h50 + i);
         step();
      end
      step();
      tests++;
      if (bus.q_count !== 3'd2 || bus.tx_kind !== KIND_RD || bus.mem_gnt_rx !== 1'b1) begin
         fails++;
         $display("[TB] FAIL rstmid_setup: got q=%0d kind=%0d gnt_rx=%0d, expected 2/1/1",
                  bus.q_count, bus.tx_kind, bus.mem_gnt_rx);
      end
      #2;
      reset = 1'b1;
      #1;
      tests++;
      if (all_outputs() !== '0) begin
         fails++;
         $display("[TB] FAIL rstmid_outputs: got %h, expected 0", all_outputs());
      end
      @(negedge inp_clk);
      reset          = 1'b0;
      bus.rx_mem_req = 1'b0;
      seen = 0;
      repeat (10) begin
         step();
         if (bus.tx_start === 1'b1) seen++;
      end
      tests++;
      if (seen !== 0 || bus.q_count !== 3'd0) begin
         fails++;
         $display("[TB] FAIL rstmid_quiet: got starts=%0d q=%0d, expected 0/0", seen, bus.q_count);
      end
      bus.wr_req   = 1'b1;
      bus.req_len  = 16'd9;
      bus.req_addr = 8'h01;
      wait_start(10, lat);
      tests++;
      if (lat !== 2 || bus.tx_len !== 16'd9) begin
         fails++;
         $display("[TB] FAIL rstmid_new: got lat=%0d len=%0d, expected 2/9", lat, bus.tx_len);
      end
      ack();
   endtask

   task automatic test_random();
      ecpri_req_t mq[$];
      ecpri_req_t cur;
      ecpri_req_t e;
      bit         busy;
      bit         issue;
      bit         ovf;
      bit         grx;
      bit         gtx;
      bit         wr;
      bit         rd;
      bit         done;
      bit         pop;
      int         drops;
      int         waited;
      int         space;
      int         nd;
      logic [LEN_W-1:0]  len;
      logic [ADDR_W-1:0] addr;

      do_reset();
      cur    = '0;
      busy   = 1'b0;
      issue  = 1'b0;
      ovf    = 1'b0;
      grx    = 1'b0;
      gtx    = 1'b0;
      drops  = 0;
      waited = 0;
      for (int c = 0; c < 500; c++) begin
         tests++;
         if (bus.tx_start !== issue) begin
            fails++;
            $display("[TB] FAIL rnd_start c=%0d: got %0d, expected %0d", c, bus.tx_start, issue);
         end
         tests++;
         if ({bus.tx_kind, bus.tx_len, bus.tx_addr} !== cur) begin
            fails++;
            $display("[TB] FAIL rnd_fields c=%0d: got %h, expected %h", c,
                     {bus.tx_kind, bus.tx_len, bus.tx_addr}, cur);
         end
         tests++;
         if (int'(bus.q_count) !== mq.size()) begin
            fails++;
            $display("[TB] FAIL rnd_qcount c=%0d: got %0d, expected %0d", c, bus.q_count, mq.size());
         end
         tests++;
         if (bus.overflow !== ovf || int'(bus.drop_cnt) !== ((drops > 255) ? 255 : drops)) begin
            fails++;
            $display("[TB] FAIL rnd_drop c=%0d: got ovf=%0d cnt=%0d, expected %0d/%0d", c,
                     bus.overflow, bus.drop_cnt, ovf, (drops > 255) ? 255 : drops);
         end
         tests++;
         if ({bus.mem_gnt_rx, bus.mem_gnt_tx, bus.tx_timeout} !== {grx, gtx, 1'b0}) begin
            fails++;
            $display("[TB] FAIL rnd_grant c=%0d: got rx/tx/to=%b, expected %b", c,
                     {bus.mem_gnt_rx, bus.mem_gnt_tx, bus.tx_timeout}, {grx, gtx, 1'b0});
         end

         wr   = ($urandom_range(0, 2) == 0);
         rd   = ($urandom_range(0, 2) == 0);
         len  = ($urandom_range(0, 7) == 0) ? '0 : LEN_W'($urandom);
         addr = ADDR_W'($urandom);
         done = ($urandom_range(0, 3) == 0) || (busy && !issue && waited >= 50);
         bus.wr_req   = wr;
         bus.rd_req   = rd;
         bus.req_len  = len;
         bus.req_addr = addr;
         bus.tx_done  = done;
         if ($urandom_range(0, 3) == 0) bus.rx_mem_req = ~bus.rx_mem_req;
         if ($urandom_range(0, 3) == 0) bus.tx_mem_req = ~bus.tx_mem_req;

         pop = !busy && (mq.size() > 0);
         if (pop) cur = mq.pop_front();
         space = QDEPTH - mq.size();
         nd    = 0;
         if (wr) begin
            if (space > 0) begin
               e.kind = KIND_WR; e.len = len; e.addr = addr;
               mq.push_back(e);
               space--;
            end else nd++;
         end
         if (rd) begin
            if (space > 0) begin
               e.kind = KIND_RD; e.len = len; e.addr = addr;
               mq.push_back(e);
               space--;
            end else nd++;
         end
         ovf   = (nd > 0);
         drops = drops + nd;
         if (pop) begin
            busy  = 1'b1;
            issue = 1'b1;
         end else if (issue) begin
            issue  = 1'b0;
            waited = 0;
         end else if (busy) begin
            if (done) busy = 1'b0;
            else waited++;
         end
         if (grx) grx = bus.rx_mem_req;
         else if (gtx) gtx = bus.tx_mem_req;
         else if (bus.rx_mem_req) grx = 1'b1;
         else if (bus.tx_mem_req) gtx = 1'b1;

         step();
      end
      bus.rx_mem_req = 1'b0;
      bus.tx_mem_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_pair();
      test_overflow();
      test_saturation();
      test_timeout();
      test_arbiter();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
